// File: rtl/instruction_store_if.sv
// instruction_store_if -- load and fetch bus for instruction_store.
//   master : drives load_en/load_addr/load_data, run, instructionPointer
//   slave  : drives instruction, instr_valid, fault, words_loaded
// Parameter ADDR_W must match the instruction_store instance it connects to.
interface instruction_store_if #(parameter int ADDR_W = 8);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [25:0]       load_data;
  logic              run;
  logic [15:0]       instructionPointer;
  logic [25:0]       instruction;
  logic              instr_valid;
  logic              fault;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output load_en, load_addr, load_data, run, instructionPointer,
    input  instruction, instr_valid, fault, words_loaded
  );

  modport slave (
    input  load_en, load_addr, load_data, run, instructionPointer,
    output instruction, instr_valid, fault, words_loaded
  );
endinterface

// File: rtl/instruction_store.sv
// instruction_store -- 2^ADDR_W x 26-bit program memory with load/fetch FSM.
//   clock : sole clock, posedge
//   reset : synchronous active-high; clears state, outputs and every memory word
//   bus   : instruction_store_if.slave (load port, run level, fetch pointer,
//           fetched instruction/valid, sticky fault, saturating load count)
// States IDLE/LOAD accept loads; RUN serves one fetch per cycle with 1-cycle
// latency; FAULT is terminal until reset.
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and
// fault on a mismatching fetch.
module instruction_store #(
  parameter int ADDR_W = 8
) (
  input logic clock,
  input logic reset,
  instruction_store_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]        state;
  logic [25:0]       mem [DEPTH];
  logic [25:0]       instrQ;
  logic              validQ;
  logic              faultQ;
  logic [ADDR_W:0]   wordsLoaded;

  logic [ADDR_W-1:0] rdAddr;
  logic [25:0]       rdData;
  logic              outOfRange;
  logic              parityErr;
  logic              doWrite;

  assign rdAddr     = bus.instructionPointer[ADDR_W-1:0];
  assign rdData     = mem[rdAddr];
  assign outOfRange = (bus.instructionPointer >> ADDR_W) != 16'd0;
  assign doWrite    = bus.load_en && (state == ST_IDLE || state == ST_LOAD);

`ifdef IMEM_PARITY_EN
  // Even parity: stored bit equals XOR of the data, so data+bit has even weight.
  logic parMem [DEPTH];
  assign parityErr = (^rdData) != parMem[rdAddr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) parMem[i] <= 1'b0;
    end else if (doWrite) begin
      parMem[bus.load_addr] <= ^bus.load_data;
    end
  end
`else
  assign parityErr = 1'b0;
`endif

  // Memory lives in flops so reset can clear every word in a single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doWrite) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      instrQ      <= '0;
      validQ      <= 1'b0;
      faultQ      <= 1'b0;
      wordsLoaded <= '0;
    end else begin
      // Count stops at 2^ADDR_W (top bit set) instead of wrapping.
      if (doWrite && !wordsLoaded[ADDR_W])
        wordsLoaded <= wordsLoaded + (ADDR_W+1)'(1);
      case (state)
        ST_IDLE, ST_LOAD: begin
          validQ <= 1'b0;
          // Load wins over run when both are high.
          if (bus.load_en)  state <= ST_LOAD;
          else if (bus.run) state <= ST_RUN;
          else              state <= ST_IDLE;
        end
        ST_RUN: begin
          // A load attempt during RUN is a protocol error and beats run-low.
          if (bus.load_en) begin
            state  <= ST_FAULT;
            faultQ <= 1'b1;
            validQ <= 1'b0;
            instrQ <= '0;
          end else if (!bus.run) begin
            state  <= ST_IDLE;
            validQ <= 1'b0;
          end else if (outOfRange || parityErr) begin
            // Hand the core a NOP for the bad fetch, then stop.
            state  <= ST_FAULT;
            faultQ <= 1'b1;
            validQ <= 1'b1;
            instrQ <= '0;
          end else begin
            validQ <= 1'b1;
            instrQ <= rdData;
          end
        end
        default: begin
          state  <= ST_FAULT;
          validQ <= 1'b0;
          instrQ <= '0;
        end
      endcase
    end
  end

  assign bus.instruction  = instrQ;
  assign bus.instr_valid  = validQ;
  assign bus.fault        = faultQ;
  assign bus.words_loaded = wordsLoaded;
endmodule

// File: tb/tb_instruction_store.sv
module tb_instruction_store;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instruction_store_if #(.ADDR_W(8)) bus();

  instruction_store #(.ADDR_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.run = 1'b0;
    bus.instructionPointer = '0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [25:0] d);
    bus.load_en = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    bus.load_en = 1'b1;
    bus.load_data = 26'h3ffffff;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.load_en = 1'b0;
    checks++; if (bus.instruction !== 26'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.instruction); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", bus.fault); end
    checks++; if (bus.words_loaded !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.words_loaded); end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp [4];
    exp[0] = 26'h0400001; exp[1] = 26'h0400002; exp[2] = 26'h0400003; exp[3] = 26'h0400004;
    doReset();
    bus.load_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.load_addr = 8'(i);
      bus.load_data = exp[i];
      step();
    end
    bus.load_en = 1'b0;
    bus.run = 1'b1;
    step();  // LOAD -> RUN
    checks++; if (bus.words_loaded !== 9'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", bus.words_loaded); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_prevalid got %b exp 0", bus.instr_valid); end
    for (int i = 0; i < 4; i++) begin
      bus.instructionPointer = 16'(i);
      step();
      checks++; if (bus.instruction !== exp[i]) begin errors++; $display("FAIL b2b_instr%0d got %h exp %h", i, bus.instruction, exp[i]); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", i, bus.instr_valid); end
    end
    bus.instructionPointer = 16'd10;  // never written
    step();
    checks++; if (bus.instruction !== 26'h0) begin errors++; $display("FAIL unwritten_read got %h exp 0", bus.instruction); end
    bus.instructionPointer = 16'd3;
    step();
    bus.run = 1'b0;
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL runlow_valid got %b exp 0", bus.instr_valid); end
    checks++; if (bus.instruction !== 26'h0400004) begin errors++; $display("FAIL runlow_hold got %h exp 0400004", bus.instruction); end
    step();
    checks++; if (bus.instruction !== 26'h0400004 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_hold got %h/%b exp 0400004/0", bus.instruction, bus.instr_valid); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL b2b_fault got %b exp 0", bus.fault); end
  endtask

  task automatic test_same_cycle();
    doReset();
    bus.run = 1'b1;
    loadWord(8'd7, 26'h1234567);  // load wins over run
    checks++; if (bus.words_loaded !== 9'd1) begin errors++; $display("FAIL same_count got %0d exp 1", bus.words_loaded); end
    step();  // LOAD -> RUN
    bus.instructionPointer = 16'd7;
    step();
    checks++; if (bus.instruction !== 26'h1234567 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL same_fetch got %h/%b exp 1234567/1", bus.instruction, bus.instr_valid); end
  endtask

  task automatic test_out_of_range();
    doReset();
    loadWord(8'd0, 26'h2aaaaaa);
    bus.run = 1'b1;
    step();
    bus.instructionPointer = 16'd0;
    step();
    checks++; if (bus.instruction !== 26'h2aaaaaa) begin errors++; $display("FAIL oob_pre got %h exp 2aaaaaa", bus.instruction); end
    bus.instructionPointer = 16'h0100;
    step();
    checks++; if (bus.instruction !== 26'h0) begin errors++; $display("FAIL oob_instr got %h exp 0", bus.instruction); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL oob_valid got %b exp 1", bus.instr_valid); end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL oob_fault got %b exp 1", bus.fault); end
    bus.instructionPointer = 16'd0;
    step();
    checks++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 26'h0) begin errors++; $display("FAIL fault_out got %h/%b exp 0/0", bus.instruction, bus.instr_valid); end
    bus.load_en = 1'b1;
    bus.load_addr = 8'd1;
    bus.load_data = 26'h1;
    step();
    bus.load_en = 1'b0;
    checks++; if (bus.words_loaded !== 9'd1) begin errors++; $display("FAIL fault_noload got %0d exp 1", bus.words_loaded); end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", bus.fault); end
  endtask

  task automatic test_load_in_run();
    doReset();
    loadWord(8'd2, 26'h0000abc);
    bus.run = 1'b1;
    step();
    bus.load_en = 1'b1;
    bus.load_addr = 8'd2;
    bus.load_data = 26'h0000def;
    step();
    bus.load_en = 1'b0;
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL runload_fault got %b exp 1", bus.fault); end
    checks++; if (bus.words_loaded !== 9'd1) begin errors++; $display("FAIL runload_count got %0d exp 1", bus.words_loaded); end
    checks++; if (dut.mem[2] !== 26'h0000abc) begin errors++; $display("FAIL runload_mem got %h exp 0000abc", dut.mem[2]); end
  endtask

  task automatic test_reset_mid_run();
    doReset();
    loadWord(8'd0, 26'h0155555);
    bus.run = 1'b1;
    step();
    bus.instructionPointer = 16'd0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.instruction !== 26'h0 || bus.instr_valid !== 1'b0 || bus.fault !== 1'b0 || bus.words_loaded !== 9'd0) begin
      errors++; $display("FAIL midrun_reset got %h/%b/%b/%0d exp 0/0/0/0", bus.instruction, bus.instr_valid, bus.fault, bus.words_loaded);
    end
    step();  // IDLE -> RUN
    step();  // fetch 0
    checks++; if (bus.instruction !== 26'h0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL midrun_cleared got %h/%b exp 0/1", bus.instruction, bus.instr_valid); end
  endtask

  task automatic test_saturate();
    doReset();
    bus.load_en = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.load_addr = 8'(i);
      bus.load_data = 26'(i);
      step();
    end
    checks++; if (bus.words_loaded !== 9'd256) begin errors++; $display("FAIL sat_count got %0d exp 256", bus.words_loaded); end
    bus.load_addr = 8'd9;
    bus.load_data = 26'd9;
    step();
    bus.load_en = 1'b0;
    checks++; if (bus.words_loaded !== 9'd256) begin errors++; $display("FAIL sat_hold got %0d exp 256", bus.words_loaded); end
    bus.run = 1'b1;
    step();
    bus.instructionPointer = 16'd0;  // rewritten by the 257th load
    step();
    checks++; if (bus.instruction !== 26'd256) begin errors++; $display("FAIL sat_rewrite got %h exp 100", bus.instruction); end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    doReset();
    loadWord(8'd5, 26'h0000007);
    dut.parMem[5] = ~dut.parMem[5];
    bus.run = 1'b1;
    step();
    bus.instructionPointer = 16'd5;
    step();
    checks++; if (bus.instruction !== 26'h0 || bus.fault !== 1'b1 || bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL parity got %h/%b/%b exp 0/1/1", bus.instruction, bus.fault, bus.instr_valid);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_back_to_back();
    test_same_cycle();
    test_out_of_range();
    test_load_in_run();
    test_reset_mid_run();
    test_saturate();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
